io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder.sv | 129 ++++++++++++
 tb/tb_io_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// CPU-facing IO port window: a TX FIFO, an RX FIFO, sticky error flags, an LED register
// and synchronized switch inputs, all mapped onto five consecutive port addresses.
module io_responder #(
    parameter logic [7:0] BASE  = 8'h10,
    parameter int         DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_adrs,
    input  logic [15:0] io_wdata,
    input  logic        io_we,
    output logic [15:0] io_rdata,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] led,
    input  logic [15:0] sw
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] FULL   = 4'(DEPTH);
    localparam logic [7:0] A_TX   = BASE;
    localparam logic [7:0] A_CLR  = BASE + 8'd1;
    localparam logic [7:0] A_RX   = BASE + 8'd2;
    localparam logic [7:0] A_LED  = BASE + 8'd3;
    localparam logic [7:0] A_SW   = BASE + 8'd4;

    logic          we_q;
    logic          wr_ev;
    logic [15:0]   tx_mem [DEPTH];
    logic [15:0]   rx_mem [DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [3:0]    tx_count, rx_count;
    logic          tx_ovf, rx_udf;
    logic [15:0]   sw_s1, sw_s2;

    logic tx_req, tx_full, tx_push, tx_pop, tx_ovf_set;
    logic rx_req, rx_push, rx_pop, rx_udf_set, clr_ev;

    // A CPU write is only the rising edge of io_we, so a long strobe counts once.
    assign wr_ev      = io_we & ~we_q;

    assign tx_valid   = (tx_count != 4'd0);
    assign tx_data    = tx_mem[tx_rptr];
    assign tx_pop     = tx_valid & tx_ready;
    assign tx_full    = (tx_count == FULL);
    assign tx_req     = wr_ev && (io_adrs == A_TX);
    assign tx_push    = tx_req && (!tx_full || tx_pop);
    assign tx_ovf_set = tx_req && tx_full && !tx_pop;

    assign rx_ready   = (rx_count != FULL);
    assign rx_push    = rx_valid & rx_ready;
    assign rx_req     = wr_ev && (io_adrs == A_RX);
    assign rx_pop     = rx_req && (rx_count != 4'd0);
    assign rx_udf_set = rx_req && (rx_count == 4'd0);

    assign clr_ev     = wr_ev && (io_adrs == A_CLR);

    always_ff @(posedge clk) begin
        if (!rst && tx_push)
            tx_mem[tx_wptr] <= io_wdata;
        if (!rst && rx_push)
            rx_mem[rx_wptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b1;
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= 4'd0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= 4'd0;
            tx_ovf   <= 1'b0;
            rx_udf   <= 1'b0;
            led      <= 16'h0000;
            sw_s1    <= 16'h0000;
            sw_s2    <= 16'h0000;
        end else begin
            we_q  <= io_we;
            sw_s1 <= sw;
            sw_s2 <= sw_s1;

            if (tx_push)
                tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)
                tx_rptr <= tx_rptr + 1'b1;
            if (tx_push && !tx_pop)
                tx_count <= tx_count + 4'd1;
            else if (!tx_push && tx_pop)
                tx_count <= tx_count - 4'd1;

            if (rx_push)
                rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)
                rx_rptr <= rx_rptr + 1'b1;
            if (rx_push && !rx_pop)
                rx_count <= rx_count + 4'd1;
            else if (!rx_push && rx_pop)
                rx_count <= rx_count - 4'd1;

            // Sticky flags: a set in the same cycle beats a write-1 clear.
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(clr_ev & io_wdata[8]));
            rx_udf <= rx_udf_set | (rx_udf & ~(clr_ev & io_wdata[9]));

            if (wr_ev && (io_adrs == A_LED))
                led <= io_wdata;
        end
    end

    always_comb begin
        io_rdata = 16'h0000;
        if (io_adrs == A_TX)
            io_rdata = {12'b0, tx_count};
        else if (io_adrs == A_CLR)
            io_rdata = {6'b0, rx_udf, tx_ovf, rx_count, tx_count};
        else if (io_adrs == A_RX)
            io_rdata = (rx_count != 4'd0) ? rx_mem[rx_rptr] : 16'h0000;
        else if (io_adrs == A_LED)
            io_rdata = led;
        else if (io_adrs == A_SW)
            io_rdata = sw_s2;
    end

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed scenarios plus randomized traffic
// compared against a queue-based model of the port window.
module tb_io_responder;

    localparam logic [7:0] BASE  = 8'h10;
    localparam int         DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  io_adrs = 8'h00;
    logic [15:0] io_wdata = 16'h0000;
    logic        io_we = 1'b0;
    logic [15:0] io_rdata;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] rx_data = 16'h0000;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] led;
    logic [15:0] sw = 16'h0000;

    int tests_run = 0;
    int failed = 0;

    io_responder #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .io_adrs(io_adrs), .io_wdata(io_wdata), .io_we(io_we),
        .io_rdata(io_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .led(led), .sw(sw)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_tx[$];
    logic [15:0] m_rx[$];
    logic        m_ovf = 1'b0, m_udf = 1'b0, m_we_last = 1'b1;
    logic [15:0] m_led = 16'h0, m_sw1 = 16'h0, m_sw2 = 16'h0;

    task automatic model_step();
        logic ev, txp;
        int   nrx;
        if (rst) begin
            m_tx.delete(); m_rx.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_led = 16'h0;
            m_sw1 = 16'h0; m_sw2 = 16'h0; m_we_last = 1'b1;
        end else begin
            ev  = io_we && !m_we_last;
            txp = (m_tx.size() != 0) && tx_ready;
            if (ev && io_adrs == BASE) begin
                if (m_tx.size() < DEPTH || txp) begin
                    if (txp) void'(m_tx.pop_front());
                    m_tx.push_back(io_wdata);
                    txp = 1'b0;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (txp) void'(m_tx.pop_front());
            nrx = m_rx.size();
            if (ev && io_adrs == BASE + 8'd1) begin
                if (io_wdata[8]) m_ovf = 1'b0;
                if (io_wdata[9]) m_udf = 1'b0;
            end
            if (ev && io_adrs == BASE + 8'd2) begin
                if (nrx != 0) void'(m_rx.pop_front());
                else m_udf = 1'b1;
            end
            if (rx_valid && nrx < DEPTH) m_rx.push_back(rx_data);
            if (ev && io_adrs == BASE + 8'd3) m_led = io_wdata;
            m_sw2 = m_sw1;
            m_sw1 = sw;
            m_we_last = io_we;
        end
    endtask

    function automatic logic [15:0] exp_rdata(input logic [7:0] a);
        logic [3:0] tc, rc;
        tc = 4'(m_tx.size());
        rc = 4'(m_rx.size());
        if (a == BASE)             return {12'b0, tc};
        if (a == BASE + 8'd1)      return {6'b0, m_udf, m_ovf, rc, tc};
        if (a == BASE + 8'd2)      return (m_rx.size() != 0) ? m_rx[0] : 16'h0;
        if (a == BASE + 8'd3)      return m_led;
        if (a == BASE + 8'd4)      return m_sw2;
        return 16'h0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
        io_adrs = a; io_wdata = d; io_we = 1'b1;
        tick();
        io_we = 1'b0;
        tick();
    endtask

    task automatic read_port(input logic [7:0] a, output logic [15:0] d);
        io_adrs = a;
        #1;
        d = io_rdata;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        rst = 1'b1; io_we = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || led !== 16'h0) begin
            failed++;
            $display("[TB] FAIL reset_outputs: tx_valid=%b rx_ready=%b led=%h, want 0 1 0000", tx_valid, rx_ready, led);
        end
        read_port(BASE + 8'd1, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            failed++;
            $display("[TB] FAIL reset_status: got %h want 0000", rd);
        end
    endtask

    task automatic test_we_level();
        logic [15:0] rd;
        io_adrs = BASE; io_wdata = 16'hA5A5; io_we = 1'b1;
        tick(); tick();
        io_we = 1'b0;
        tick();
        read_port(BASE, rd);
        tests_run++;
        if (rd !== 16'h0001 || tx_data !== 16'hA5A5 || tx_valid !== 1'b1) begin
            failed++;
            $display("[TB] FAIL we_level: count=%h data=%h valid=%b, want 0001 A5A5 1", rd, tx_data, tx_valid);
        end
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    endtask

    task automatic test_tx_overflow();
        logic [15:0] rd;
        for (int i = 1; i <= 9; i++) cpu_write(BASE, 16'h1000 + 16'(i));
        read_port(BASE, rd);
        tests_run++;
        if (rd !== 16'h0008) begin
            failed++;
            $display("[TB] FAIL ovf_count: got %h want 0008", rd);
        end
        read_port(BASE + 8'd1, rd);
        tests_run++;
        if (rd !== 16'h0108) begin
            failed++;
            $display("[TB] FAIL ovf_status: got %h want 0108", rd);
        end
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== 16'h1000 + 16'(i)) begin
                failed++;
                $display("[TB] FAIL ovf_drain_%0d: valid=%b data=%h want 1 %h", i, tx_valid, tx_data, 16'h1000 + 16'(i));
            end
            tick();
        end
        tx_ready = 1'b0;
        tests_run++;
        if (tx_valid !== 1'b0) begin
            failed++;
            $display("[TB] FAIL ovf_empty: tx_valid=%b want 0", tx_valid);
        end
        cpu_write(BASE + 8'd1, 16'h0100);
        read_port(BASE + 8'd1, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            failed++;
            $display("[TB] FAIL ovf_clear: got %h want 0000", rd);
        end
    endtask

    task automatic test_rx_underflow();
        logic [15:0] rd;
        rx_data = 16'h1234; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        read_port(BASE + 8'd2, rd);
        tests_run++;
        if (rd !== 16'h1234) begin
            failed++;
            $display("[TB] FAIL rx_head: got %h want 1234", rd);
        end
        cpu_write(BASE + 8'd2, 16'hFFFF);
        read_port(BASE + 8'd1, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            failed++;
            $display("[TB] FAIL rx_pop: status %h want 0000", rd);
        end
        cpu_write(BASE + 8'd2, 16'h0000);
        read_port(BASE + 8'd1, rd);
        tests_run++;
        if (rd !== 16'h0200) begin
            failed++;
            $display("[TB] FAIL rx_udf: status %h want 0200", rd);
        end
        cpu_write(BASE + 8'd1, 16'h0200);
    endtask

    task automatic test_full_push_pop();
        logic [15:0] rd;
        logic [15:0] expq[$];
        for (int i = 0; i < 8; i++) cpu_write(BASE, 16'hC000 + 16'(i));
        io_adrs = BASE; io_wdata = 16'hC0DE; io_we = 1'b1; tx_ready = 1'b1;
        tick();
        io_we = 1'b0; tx_ready = 1'b0;
        tick();
        read_port(BASE + 8'd1, rd);
        tests_run++;
        if (rd !== 16'h0008) begin
            failed++;
            $display("[TB] FAIL full_pushpop: status %h want 0008", rd);
        end
        for (int i = 1; i < 8; i++) expq.push_back(16'hC000 + 16'(i));
        expq.push_back(16'hC0DE);
        tx_ready = 1'b1;
        foreach (expq[i]) begin
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== expq[i]) begin
                failed++;
                $display("[TB] FAIL full_drain_%0d: valid=%b data=%h want 1 %h", i, tx_valid, tx_data, expq[i]);
            end
            tick();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_led_sw();
        logic [15:0] rd;
        cpu_write(BASE + 8'd3, 16'hBEEF);
        tests_run++;
        if (led !== 16'hBEEF) begin
            failed++;
            $display("[TB] FAIL led: got %h want BEEF", led);
        end
        sw = 16'h00FF;
        tick(); tick();
        read_port(BASE + 8'd4, rd);
        tests_run++;
        if (rd !== 16'h00FF) begin
            failed++;
            $display("[TB] FAIL sw_sync: got %h want 00FF", rd);
        end
        read_port(8'h20, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            failed++;
            $display("[TB] FAIL out_of_window: got %h want 0000", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        for (int i = 0; i < 3; i++) cpu_write(BASE, 16'h7700 + 16'(i));
        rx_data = 16'h5555; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        io_adrs = BASE + 8'd3; io_wdata = 16'h1234; io_we = 1'b1; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        tests_run++;
        if (tx_valid !== 1'b0 || led !== 16'h0000 || rx_ready !== 1'b1) begin
            failed++;
            $display("[TB] FAIL reset_mid: tx_valid=%b led=%h rx_ready=%b want 0 0000 1", tx_valid, led, rx_ready);
        end
        read_port(BASE + 8'd2, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            failed++;
            $display("[TB] FAIL reset_mid_rx: got %h want 0000", rd);
        end
        io_adrs = BASE + 8'd3;
        io_we = 1'b0; tick();
        io_we = 1'b1; tick();
        io_we = 1'b0; tick();
        tests_run++;
        if (led !== 16'h1234) begin
            failed++;
            $display("[TB] FAIL reset_mid_toggle: led=%h want 1234", led);
        end
    endtask

    task automatic test_random();
        logic [15:0] rd, ex;
        logic [7:0]  ra;
        int          sel;
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            sel      = int'($urandom_range(0, 6));
            io_adrs  = (sel == 6) ? 8'h20 : BASE + 8'(sel);
            io_wdata = 16'($urandom);
            io_we    = 1'($urandom_range(0, 1));
            tx_ready = ($urandom_range(0, 3) == 0);
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 16'($urandom);
            sw       = 16'($urandom);
            tick();
            tests_run++;
            if (tx_valid !== (m_tx.size() != 0) || rx_ready !== (m_rx.size() != DEPTH) || led !== m_led ||
                (m_tx.size() != 0 && tx_data !== m_tx[0])) begin
                failed++;
                $display("[TB] FAIL rand_out_%0d: tx_valid=%b tx_data=%h rx_ready=%b led=%h want %b %h %b %h", n,
                         tx_valid, tx_data, rx_ready, led, m_tx.size() != 0,
                         (m_tx.size() != 0) ? m_tx[0] : 16'h0, m_rx.size() != DEPTH, m_led);
            end
            sel = int'($urandom_range(0, 6));
            ra  = (sel == 6) ? 8'h20 : BASE + 8'(sel);
            read_port(ra, rd);
            ex = exp_rdata(ra);
            tests_run++;
            if (rd !== ex) begin
                failed++;
                $display("[TB] FAIL rand_read_%0d adr=%h: got %h want %h", n, ra, rd, ex);
            end
        end
        rst = 1'b0; io_we = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_we_level();
        test_tx_overflow();
        test_rx_underflow();
        test_full_push_pop();
        test_led_sw();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
